// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode field geometry, width defaults and
// opcode constants also used by the opcode decoder.
package cpu_defs;

  localparam int unsigned AddrWDef  = 8;
  localparam int unsigned InstrWDef = 16;
  localparam int unsigned OpcodeW   = 5;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StLoad  = 2'b01,
    StIdle  = 2'b10,
    StExec  = 2'b11
  } fetch_state_e;

  localparam logic [OpcodeW-1:0] OpNop  = 5'h00;
  localparam logic [OpcodeW-1:0] OpLd   = 5'h01;
  localparam logic [OpcodeW-1:0] OpSt   = 5'h02;
  localparam logic [OpcodeW-1:0] OpAdd  = 5'h03;
  localparam logic [OpcodeW-1:0] OpSub  = 5'h04;
  localparam logic [OpcodeW-1:0] OpJmp  = 5'h05;
  localparam logic [OpcodeW-1:0] OpJz   = 5'h06;
  localparam logic [OpcodeW-1:0] OpJc   = 5'h07;
  localparam logic [OpcodeW-1:0] OpHalt = 5'h1F;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: branch resolution and sequential increment (wraps at 2^ADDR_W).
module pc_next #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  logic              ldpc,
  input  logic              jz,
  input  logic              jc,
  input  logic              jump,
  input  logic              zflag,
  input  logic              cflag,
  output logic [ADDR_W-1:0] pc_nxt
);

  logic taken;

  // Resolve branch and pick target, increment, or hold
  always_comb begin
    taken  = jump | (jz & zflag) | (jc & cflag);
    pc_nxt = pc;
    if (ldpc) begin
      pc_nxt = taken ? target : pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing unit: owns PC and IR, reads the synchronous instruction
// memory and advances one instruction per step pulse.
// Optional macro FETCH_FREERUN_EN adds a 'run' input that acts as a permanent step in IDLE.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned INSTR_W = InstrWDef
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
`ifdef FETCH_FREERUN_EN
  input  logic               run,
`endif
  input  logic               LDPC,
  input  logic               LDIR,
  input  logic               JZ,
  input  logic               JC,
  input  logic               JUMP,
  input  logic               zflag,
  input  logic               cflag,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] IR,
  output logic [OpcodeW-1:0] OpCode,
  output logic               exec_en,
  output logic               busy
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_nxt;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               go;

`ifdef FETCH_FREERUN_EN
  assign go = step | run;
`else
  assign go = step;
`endif

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc     (pc_q),
    .target (ir_q[ADDR_W-1:0]),
    .ldpc   (LDPC),
    .jz     (JZ),
    .jc     (JC),
    .jump   (JUMP),
    .zflag  (zflag),
    .cflag  (cflag),
    .pc_nxt (pc_nxt)
  );

  // Next-state, PC and IR update selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: state_d = StLoad;
      StLoad: begin
        ir_d    = imem_data;
        state_d = StIdle;
      end
      StIdle: begin
        if (go) state_d = StExec;
      end
      StExec: begin
        pc_d    = pc_nxt;
        state_d = LDIR ? StFetch : StIdle;
      end
      default: state_d = StFetch;
    endcase
  end

  // State, PC and IR registers; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decoded straight from registers so reset clears them immediately
  always_comb begin
    PC        = pc_q;
    imem_addr = pc_q;
    IR        = ir_q;
    OpCode    = ir_q[INSTR_W-1 -: OpcodeW];
    exec_en   = (state_q == StExec);
    busy      = (state_q == StFetch) || (state_q == StLoad);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected PC/IR of each fetch,
// a monitor pops and compares whenever the unit returns to IDLE after a load.
module tb_fetch_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic        LDPC = 1'b0, LDIR = 1'b0, JZ = 1'b0, JC = 1'b0, JUMP = 1'b0;
  logic        zflag = 1'b0, cflag = 1'b0;
  logic [15:0] imem_data;
  logic [7:0]  imem_addr, PC;
  logic [15:0] IR;
  logic [4:0]  OpCode;
  logic        exec_en, busy;

  logic [15:0] mem [256];

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ir;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  logic busy_prev = 1'b1;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (8),
    .INSTR_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
`ifdef FETCH_FREERUN_EN
    .run       (1'b0),
`endif
    .LDPC      (LDPC),
    .LDIR      (LDIR),
    .JZ        (JZ),
    .JC        (JC),
    .JUMP      (JUMP),
    .zflag     (zflag),
    .cflag     (cflag),
    .imem_data (imem_data),
    .imem_addr (imem_addr),
    .PC        (PC),
    .IR        (IR),
    .OpCode    (OpCode),
    .exec_en   (exec_en),
    .busy      (busy)
  );

  // Synchronous instruction memory: data one cycle after address
  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: each completed load (busy falling) must match the oldest expectation
  always @(negedge clk) begin
    if (busy_prev && !busy) begin
      if (sb.size() == 0) begin
        check("unexpected_fetch", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("fetch_pc", {24'd0, PC}, {24'd0, mon_e.pc});
        check("fetch_ir", {16'd0, IR}, {16'd0, mon_e.ir});
        check("fetch_opcode", {27'd0, OpCode}, {27'd0, mon_e.ir[15:11]});
      end
    end
    busy_prev = busy;
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Execute one instruction from IDLE; caller is positioned just after a negedge
  task automatic exec_instr(input logic ldpc, input logic ldir, input logic jump,
                            input logic jz, input logic jc, input logic z, input logic c,
                            input logic [7:0] exp_pc, input bit load_step);
    exp_t e;
    if (ldir) begin
      e.pc = exp_pc;
      e.ir = mem[exp_pc];
      sb.push_back(e);
    end
    step = 1'b1;
    LDPC = ldpc; LDIR = ldir; JUMP = jump; JZ = jz; JC = jc; zflag = z; cflag = c;
    @(negedge clk);
    check("exec_en_on", {31'd0, exec_en}, 32'd1);
    step = 1'b0;
    @(negedge clk);
    check("exec_en_off", {31'd0, exec_en}, 32'd0);
    check("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    LDPC = 0; LDIR = 0; JUMP = 0; JZ = 0; JC = 0; zflag = 0; cflag = 0;
    if (load_step) begin
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end else begin
      wait_idle();
    end
  endtask

  initial begin
    bit saw;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0800;
    mem[8'h01] = 16'h103C;
    mem[8'h3C] = 16'h1850;
    mem[8'h3D] = 16'h2060;
    mem[8'h60] = 16'h2870;
    mem[8'h61] = 16'h3080;
    mem[8'h80] = 16'h38FF;
    mem[8'hFF] = 16'h4011;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", {24'd0, PC}, 32'd0);
    check("rst_ir", {16'd0, IR}, 32'd0);
    check("rst_opcode", {27'd0, OpCode}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_exec_en", {31'd0, exec_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // Automatic first fetch of address 0
    sb.push_back('{pc: 8'h00, ir: 16'h0800});
    rst = 1'b1;
    #1;
    check("c0_busy", {31'd0, busy}, 32'd1);
    check("c0_addr", {24'd0, imem_addr}, 32'd0);
    @(negedge clk);
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_exec_en", {31'd0, exec_en}, 32'd0);
    @(negedge clk);
    check("c2_busy", {31'd0, busy}, 32'd0);
    check("c2_exec_en", {31'd0, exec_en}, 32'd0);

    // Sequential, jump, conditional branches both ways, wrap
    exec_instr(1, 1, 0, 0, 0, 0, 0, 8'h01, 0);
    exec_instr(1, 1, 1, 0, 0, 0, 0, 8'h3C, 0);
    exec_instr(1, 1, 0, 1, 0, 0, 0, 8'h3D, 0);
    exec_instr(1, 1, 0, 1, 0, 1, 0, 8'h60, 0);
    exec_instr(1, 1, 0, 0, 1, 0, 0, 8'h61, 0);
    exec_instr(1, 1, 0, 0, 1, 0, 1, 8'h80, 0);
    exec_instr(1, 1, 1, 0, 0, 0, 0, 8'hFF, 0);
    exec_instr(1, 1, 0, 0, 0, 0, 0, 8'h00, 1);

    // Step pulsed during LOAD must not start an execution
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (exec_en) saw = 1;
    end
    check("load_step_ignored", {31'd0, saw}, 32'd0);
    check("idle_hold_busy", {31'd0, busy}, 32'd0);

    // No LDPC, no LDIR: stays put, back to IDLE without a fetch
    exec_instr(0, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    check("noload_pc", {24'd0, PC}, 32'd0);
    check("noload_ir", {16'd0, IR}, 32'h0800);
    check("noload_busy", {31'd0, busy}, 32'd0);

    exec_instr(1, 1, 0, 0, 0, 0, 0, 8'h01, 0);

    // Reset mid-EXEC aborts the jump
    step = 1'b1; LDPC = 1; LDIR = 1; JUMP = 1;
    @(negedge clk);
    check("abort_exec_en_on", {31'd0, exec_en}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_exec_en", {31'd0, exec_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_pc", {24'd0, PC}, 32'd0);
    step = 1'b0; LDPC = 0; LDIR = 0; JUMP = 0;
    @(negedge clk);
    check("abort_pc_hold", {24'd0, PC}, 32'd0);
    sb.push_back('{pc: 8'h00, ir: 16'h0800});
    rst = 1'b1;
    wait_idle();
    @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
